// File: rtl/vga_timing_ctrl_p.sv
// vga_timing_ctrl_p: parametrised VGA timing generator with frame-buffer fetch addressing and registered pixel/sync alignment
module vga_timing_ctrl_p #(
    parameter int H_FRONT = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_ACT   = 640,
    parameter int V_FRONT = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BACK  = 33,
    parameter int V_ACT   = 480,
    parameter int H_DLY   = 2,
    parameter int HS_POL  = 0,
    parameter int VS_POL  = 0,
    parameter int COLOR_W = 10,
    parameter int ADDR_W  = 22
) (
    input  logic               iCLK,
    input  logic               iRST,
    input  logic               iCE,
    input  logic [COLOR_W-1:0] iRed,
    input  logic [COLOR_W-1:0] iGreen,
    input  logic [COLOR_W-1:0] iBlue,
    output logic               oRequest,
    output logic [10:0]        oCurrent_X,
    output logic [10:0]        oCurrent_Y,
    output logic [ADDR_W-1:0]  oAddress,
    output logic               oLine_Start,
    output logic               oFrame_Start,
    output logic [COLOR_W-1:0] oVGA_R,
    output logic [COLOR_W-1:0] oVGA_G,
    output logic [COLOR_W-1:0] oVGA_B,
    output logic               oVGA_HS,
    output logic               oVGA_VS,
    output logic               oVGA_BLANK,
    output logic               oVGA_SYNC
);
    localparam int H_BLANK = H_FRONT + H_SYNC + H_BACK;
    localparam int H_TOTAL = H_BLANK + H_ACT;
    localparam int V_BLANK = V_FRONT + V_SYNC + V_BACK;
    localparam int V_TOTAL = V_BLANK + V_ACT;
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_REQ_S  = HW'(H_BLANK - H_DLY);
    localparam logic [HW-1:0] H_REQ_E  = HW'(H_TOTAL - H_DLY);
    localparam logic [HW-1:0] H_ACT_S  = HW'(H_BLANK);
    localparam logic [HW-1:0] H_SYNC_S = HW'(H_FRONT);
    localparam logic [HW-1:0] H_SYNC_E = HW'(H_FRONT + H_SYNC);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_S  = VW'(V_BLANK);
    localparam logic [VW-1:0] V_SYNC_S = VW'(V_FRONT);
    localparam logic [VW-1:0] V_SYNC_E = VW'(V_FRONT + V_SYNC);
    localparam logic HS_ON = 1'(HS_POL);
    localparam logic VS_ON = 1'(VS_POL);

    if (H_DLY < 0 || H_DLY >= H_BLANK) begin : gBadDelay
        $error("H_DLY must lie in [0, H_BLANK)");
    end
    if (longint'(H_ACT) * longint'(V_ACT) > (longint'(1) << ADDR_W)) begin : gBadAddr
        $error("ADDR_W too narrow for H_ACT*V_ACT");
    end

    logic [HW-1:0] hCont;
    logic [VW-1:0] vCont;
    logic hEnd, vEnd, hReq, vAct, hSyncOn, vSyncOn, active;

    always_comb begin
        hEnd         = hCont == H_LAST;
        vEnd         = vCont == V_LAST;
        hReq         = hCont >= H_REQ_S && hCont < H_REQ_E;
        vAct         = vCont >= V_ACT_S;
        hSyncOn      = hCont >= H_SYNC_S && hCont < H_SYNC_E;
        vSyncOn      = vCont >= V_SYNC_S && vCont < V_SYNC_E;
        active       = hCont >= H_ACT_S && vAct;
        oRequest     = hReq && vAct;
        oCurrent_X   = oRequest ? 11'(hCont - H_REQ_S) : 11'd0;
        oCurrent_Y   = vAct ? 11'(vCont - V_ACT_S) : 11'd0;
        oLine_Start  = iCE && hCont == '0;
        oFrame_Start = oLine_Start && vCont == '0;
        oVGA_SYNC    = 1'b1;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            hCont    <= '0;
            vCont    <= '0;
            oAddress <= '0;
        end else if (iCE) begin
            hCont <= hEnd ? '0 : hCont + 1'b1;
            if (hEnd)
                vCont <= vEnd ? '0 : vCont + 1'b1;
            // running count of fetched pixels replaces a Y*H_ACT+X multiplier
            oAddress <= oFrame_Start ? '0 : oAddress + ADDR_W'(oRequest);
        end
    end

    // output stage registers the counter decode so colour, blank and sync leave together
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oVGA_HS    <= ~HS_ON;
            oVGA_VS    <= ~VS_ON;
            oVGA_BLANK <= 1'b0;
            oVGA_R     <= '0;
            oVGA_G     <= '0;
            oVGA_B     <= '0;
        end else if (iCE) begin
            oVGA_HS    <= hSyncOn ? HS_ON : ~HS_ON;
            oVGA_VS    <= vSyncOn ? VS_ON : ~VS_ON;
            oVGA_BLANK <= active;
            oVGA_R     <= active ? iRed : '0;
            oVGA_G     <= active ? iGreen : '0;
            oVGA_B     <= active ? iBlue : '0;
        end
    end
endmodule
